// File: rtl/apb_global_pkg.sv
// Shared APB types and constants.
//   NO_OF_SLAVES       width of the pselx bus
//   MAX_WAIT_STATES    largest wait-state count a completer may insert
//   tx_type_e          transfer direction as driven on pwrite
//   slave_error_e      completer response as driven on pslverr
//   slave_fsm_state_e  completer transfer state
package apb_global_pkg;

   localparam int NO_OF_SLAVES    = 1;
   localparam int MAX_WAIT_STATES = 15;

   typedef enum bit {READ = 1'b0, WRITE = 1'b1} tx_type_e;

   typedef enum bit {NO_ERROR = 1'b0, ERROR = 1'b1} slave_error_e;

   typedef enum bit {SLAVE_IDLE = 1'b0, SLAVE_ACCESS = 1'b1} slave_fsm_state_e;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Byte-enabled word storage for the APB memory completer.
//   pclk    in   clock, write and clear on rising edge
//   preset  in   synchronous active-high clear of every word
//   we      in   write enable for word idx
//   idx     in   word index (write and read)
//   strb    in   byte lanes written when we=1
//   wdata   in   write data
//   rdata   out  combinational read of word idx
module apb_slave_mem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 16,
   parameter int unsigned IDX_WIDTH  = 4
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    we,
   input  logic [IDX_WIDTH-1:0]    idx,
   input  logic [DATA_WIDTH/8-1:0] strb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] lane_mask;
   logic [DATA_WIDTH-1:0] words [MEM_DEPTH];

   for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
      assign lane_mask[b*8 +: 8] = {8{strb[b]}};
   end

   // One register per word so every index is a constant; lanes are merged
   // through a mask instead of per-byte writes.
   for (genvar w = 0; w < MEM_DEPTH; w++) begin : g_word
      logic [DATA_WIDTH-1:0] word_q;

      always_ff @(posedge pclk) begin
         if (preset) begin
            word_q <= '0;
         end else if (we && (idx == IDX_WIDTH'(w))) begin
            word_q <= (word_q & ~lane_mask) | (wdata & lane_mask);
         end
      end

      assign words[w] = word_q;
   end

   assign rdata = words[idx];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer with byte-strobed memory and programmable wait states.
//   pclk             in   APB clock
//   preset           in   synchronous active-high reset
//   pselx            in   one-hot selects; bit SLAVE_INDEX addresses this instance
//   penable          in   access-phase indicator
//   pwrite           in   1 = WRITE, 0 = READ
//   paddr            in   byte address
//   pwdata           in   write data
//   pstrb            in   write byte lanes
//   pprot            in   protection attributes (bit 0 = privileged)
//   wait_states_cfg  in   wait states for the next transfer, sampled in setup
//   pready           out  transfer completes this cycle
//   prdata           out  read data, nonzero only in an OKAY read pready cycle
//   pslverr          out  error response, only asserted with pready
module apb_slave_mem_responder
   import apb_global_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MEM_DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int unsigned SLAVE_INDEX   = 0,
   parameter int unsigned MAX_WAIT      = MAX_WAIT_STATES,
   parameter bit          PRIV_ONLY     = 1'b0
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic [NO_OF_SLAVES-1:0]  pselx,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [ADDRESS_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0]    pwdata,
   input  logic [DATA_WIDTH/8-1:0]  pstrb,
   input  logic [2:0]               pprot,
   input  logic [3:0]               wait_states_cfg,
   output logic                     pready,
   output logic [DATA_WIDTH-1:0]    prdata,
   output logic                     pslverr
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   slave_fsm_state_e state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       wait_load;
   logic             sel, setup;

   logic [ADDRESS_WIDTH-1:0] addr_lat;
   tx_type_e                 dir_lat;
   logic [DATA_WIDTH-1:0]    wdata_lat;
   logic [STRB_WIDTH-1:0]    strb_lat;
   logic                     priv_lat;

   logic [ADDRESS_WIDTH-1:0] base, off, word;
   slave_error_e             err_status;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   assign sel       = pselx[SLAVE_INDEX];
   assign setup     = sel && !penable;
   assign wait_load = (32'(wait_states_cfg) > MAX_WAIT) ? 4'(MAX_WAIT) : wait_states_cfg;

   // State register
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= SLAVE_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Transfer attributes are captured in every setup phase, including a
   // setup that restarts an access already in progress.
   always_ff @(posedge pclk) begin
      if (preset) begin
         addr_lat  <= '0;
         dir_lat   <= READ;
         wdata_lat <= '0;
         strb_lat  <= '0;
         priv_lat  <= 1'b0;
      end else if (setup) begin
         addr_lat  <= paddr;
         dir_lat   <= tx_type_e'(pwrite);
         wdata_lat <= pwdata;
         strb_lat  <= pstrb;
         priv_lat  <= pprot[0];
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SLAVE_IDLE: begin
            if (setup) begin
               state_d = SLAVE_ACCESS;
               cnt_d   = wait_load;
            end
         end
         SLAVE_ACCESS: begin
            if (!sel) begin
               state_d = SLAVE_IDLE;
               cnt_d   = '0;
            end else if (!penable) begin
               cnt_d = wait_load;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = SLAVE_IDLE;
            end
         end
         default: begin
            state_d = SLAVE_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Decode of the latched address
   assign base = ADDRESS_WIDTH'(BASE_ADDR);
   assign off  = addr_lat - base;
   assign word = off >> ADDR_LSB;

   always_comb begin
      err_status = NO_ERROR;
      if ((addr_lat < base) ||
          (word >= ADDRESS_WIDTH'(MEM_DEPTH)) ||
          ((addr_lat & ADDRESS_WIDTH'(STRB_WIDTH - 1)) != '0) ||
          ((dir_lat == READ) && (strb_lat != '0)) ||
          (PRIV_ONLY && !priv_lat)) begin
         err_status = ERROR;
      end
   end

   // Outputs; preset also gates them so a reset in the completing cycle
   // neither answers nor commits a write.
   always_comb begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      mem_we  = 1'b0;
      if (!preset && (state_q == SLAVE_ACCESS) && sel && penable && (cnt_q == '0)) begin
         pready  = 1'b1;
         pslverr = (err_status == ERROR);
         if (err_status == NO_ERROR) begin
            if (dir_lat == WRITE) begin
               mem_we = 1'b1;
            end else begin
               prdata = mem_rdata;
            end
         end
      end
   end

   apb_slave_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_mem (
      .pclk   (pclk),
      .preset (preset),
      .we     (mem_we),
      .idx    (word[IDX_WIDTH-1:0]),
      .strb   (strb_lat),
      .wdata  (wdata_lat),
      .rdata  (mem_rdata)
   );

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// Scoreboard bench for apb_slave_mem_responder: the driver queues the
// expected response of each transfer, a monitor checks it at pready.
module tb_apb_slave_mem_responder;
   import apb_global_pkg::*;

   logic                    pclk = 1'b0;
   logic                    preset;
   logic [NO_OF_SLAVES-1:0] pselx;
   logic                    penable;
   logic                    pwrite;
   logic [31:0]             paddr;
   logic [31:0]             pwdata;
   logic [3:0]              pstrb;
   logic [2:0]              pprot;
   logic [3:0]              wait_states_cfg;
   logic                    pready;
   logic [31:0]             prdata;
   logic                    pslverr;

   always #5 pclk = ~pclk;

   apb_slave_mem_responder #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .MEM_DEPTH     (16),
      .BASE_ADDR     (32'h0),
      .SLAVE_INDEX   (0),
      .MAX_WAIT      (15),
      .PRIV_ONLY     (1'b0)
   ) dut (
      .pclk            (pclk),
      .preset          (preset),
      .pselx           (pselx),
      .penable         (penable),
      .pwrite          (pwrite),
      .paddr           (paddr),
      .pwdata          (pwdata),
      .pstrb           (pstrb),
      .pprot           (pprot),
      .wait_states_cfg (wait_states_cfg),
      .pready          (pready),
      .prdata          (prdata),
      .pslverr         (pslverr)
   );

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: counts cycles from setup, checks each completed transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (preset)                  cyc = 0;
         else if (pselx[0] && !penable) cyc = 1;
         else if (pselx[0] && penable)  cyc++;
         if (pready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pready", {31'b0, pready}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_prdata"},  prdata, e.rd);
               chk({e.name, "_pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
               chk({e.name, "_latency"}, 32'(cyc), 32'(e.lat));
            end
         end
      end
   end

   task automatic bus_idle();
      pselx   = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
   endtask

   task automatic setup_phase(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [3:0] ws);
      @(posedge pclk); #1;
      pselx           = 1'b1;
      penable         = 1'b0;
      pwrite          = wr;
      paddr           = addr;
      pwdata          = data;
      pstrb           = strb;
      wait_states_cfg = ws;
   endtask

   // Full transfer; returns at the negedge of the pready cycle so the next
   // call issues its setup in the very next cycle.
   task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic [3:0] ws,
                       input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      bit   done;
      e.rd = exp_rd; e.err = exp_err; e.lat = int'(ws) + 2; e.name = name;
      exp_q.push_back(e);
      setup_phase(wr, addr, data, strb, ws);
      @(posedge pclk); #1;
      penable = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge pclk);
         done = pready;
         if (!done) begin
            @(posedge pclk); #1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: pready not seen in 40 cycles, required at cycle %0d", name, e.lat);
         void'(exp_q.pop_back());
         bus_idle();
      end
   endtask

   task automatic go_idle();
      @(posedge pclk); #1;
      bus_idle();
   endtask

   task automatic reset_outputs_zero(input string name);
      chk({name, "_pready"},  {31'b0, pready},  32'd0);
      chk({name, "_prdata"},  prdata,           32'd0);
      chk({name, "_pslverr"}, {31'b0, pslverr}, 32'd0);
   endtask

   task automatic do_reset(input int n);
      @(posedge pclk); #1;
      preset = 1'b1;
      bus_idle();
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         reset_outputs_zero("in_reset");
      end
      @(posedge pclk); #1;
      preset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      preset          = 1'b1;
      pprot           = 3'b000;
      wait_states_cfg = '0;
      bus_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         reset_outputs_zero("reset");
      end
      @(posedge pclk); #1;
      preset = 1'b0;

      // Zero-wait write then read back
      xfer("t1_wr", 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 4'd0, 32'h0, 1'b0);
      xfer("t1_rd", 1'b0, 32'h4, 32'h0, 4'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
      go_idle();

      // Three wait states on a fresh memory; reset clears word 1 too
      do_reset(2);
      xfer("t2_rd8", 1'b0, 32'h8, 32'h0, 4'h0, 4'd3, 32'h0, 1'b0);
      xfer("t2_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);

      // Partial strobes over all-ones
      xfer("t3_fill",  1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 4'd1, 32'h0, 1'b0);
      xfer("t3_strb",  1'b1, 32'h0, 32'h1122_3344, 4'b0101, 4'd2, 32'h0, 1'b0);
      xfer("t3_rd",    1'b0, 32'h0, 32'h0, 4'h0, 4'd0, 32'hFF22_FF44, 1'b0);

      // Decode, alignment and strobe faults; memory must not change
      xfer("t4_oor",     1'b0, 32'h40, 32'h0, 4'h0, 4'd0, 32'h0, 1'b1);
      xfer("t4_misal",   1'b1, 32'h2, 32'hAAAA_AAAA, 4'hF, 4'd0, 32'h0, 1'b1);
      xfer("t4_rd0",     1'b0, 32'h0, 32'h0, 4'h0, 4'd0, 32'hFF22_FF44, 1'b0);
      xfer("t4_lastwd",  1'b0, 32'h3C, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
      xfer("t4_maxwait", 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 4'd15, 32'h0, 1'b0);
      xfer("t4_nostrb",  1'b1, 32'h4, 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
      xfer("t4_rdstrb",  1'b0, 32'h4, 32'h0, 4'h2, 4'd0, 32'h0, 1'b1);
      xfer("t4_rd4",     1'b0, 32'h4, 32'h0, 4'h0, 4'd1, 32'hDEAD_BEEF, 1'b0);
      go_idle();

      // Access phase without setup is ignored
      @(posedge pclk); #1;
      pselx = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h0; pstrb = 4'hF;
      repeat (3) @(posedge pclk);
      #1;
      bus_idle();
      xfer("stray_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);

      // Abort by dropping select after two access cycles
      xfer("t5_wr", 1'b1, 32'hC, 32'h1234_5678, 4'hF, 4'd0, 32'h0, 1'b0);
      setup_phase(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, 4'd5);
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      bus_idle();
      xfer("t5_rd", 1'b0, 32'hC, 32'h0, 4'h0, 4'd0, 32'h1234_5678, 1'b0);

      // Reset during a waited write
      setup_phase(1'b1, 32'h8, 32'h0BAD_F00D, 4'hF, 4'd4);
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      preset = 1'b1;
      bus_idle();
      for (int i = 0; i < 2; i++) begin
         @(negedge pclk);
         reset_outputs_zero("t6_reset");
      end
      @(posedge pclk); #1;
      preset = 1'b0;
      for (int w = 0; w < 16; w++) begin
         xfer($sformatf("t6_clear%0d", w), 1'b0, 32'(w * 4), 32'h0, 4'h0, 4'd0, 32'h0, 1'b0);
      end
      go_idle();

      repeat (3) @(posedge pclk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
